pwm_capture: RTL and testbench

//   Downstream measurement stage for the PWM generator. Samples a PWM waveform and reports

---
 rtl/pwm_capture.sv | 196 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of a (possibly asynchronous) PWM input.
// Latency: edge seen SYNC_STAGES+1 cycles after i_pwm moves; results published one cycle after the closing rise.
// Backpressure: none; o_valid is a single-cycle pulse and outputs hold until the next publish.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  // Reset release synchronizer: assertion is immediate, release is aligned to i_clk.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n_int;

  // Input synchronizer, edge-detect delay flop, FSM, counters and registered outputs.
  logic [SYNC_STAGES-1:0] pwm_sync_q, pwm_sync_d;
  logic                   s_d_q, s_d_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]       hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]       hi_shadow_q, hi_shadow_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]       period_cnt_q, period_cnt_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;

  logic                   pwm_s;
  logic                   rise;
  logic                   fall;
  logic                   per_sat;
  logic [CNT_W-1:0]       per_inc;
  logic [CNT_W-1:0]       hi_inc;

  // Shift a constant 1 through the reset synchronizer once i_rst_n is released.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchronizer flops; cleared asynchronously by the raw reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_int = rst_sync_q[1];

  // Edge detection and saturating increments shared by every state.
  always_comb begin
    pwm_s   = pwm_sync_q[SYNC_STAGES-1];
    rise    = pwm_s & ~s_d_q;
    fall    = ~pwm_s & s_d_q;
    per_sat = (per_cnt_q == CNT_MAX);
    per_inc = per_sat ? per_cnt_q : per_cnt_q + CNT_ONE;
    hi_inc  = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CNT_ONE;
  end

  // Next-state logic: measurement FSM, counters and publish of completed periods.
  // ARM keeps the counters at zero: anything before the first rise is a partial
  // period and is thrown away, so a valid always needs two observed rises.
  always_comb begin
    pwm_sync_d   = {pwm_sync_q[SYNC_STAGES-2:0], i_pwm};
    s_d_d        = pwm_s;
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    hi_shadow_d  = hi_shadow_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    valid_d      = 1'b0;
    timeout_d    = timeout_q;

    if (!i_enable) begin
      // Disabling abandons the current measurement; published values and timeout hold.
      state_d   = ST_IDLE;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_ARM;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
        end

        ST_ARM: begin
          if (rise) begin
            state_d   = ST_HIGH;
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            // High time is final here; keep it until the closing rise publishes it.
            state_d     = ST_LOW;
            hi_shadow_d = hi_cnt_q;
            per_cnt_d   = per_inc;
          end else if (per_sat) begin
            // Line stuck high: give up on this period and flag it.
            state_d   = ST_ARM;
            timeout_d = 1'b1;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
          end else begin
            per_cnt_d = per_inc;
            hi_cnt_d  = hi_inc;
          end
        end

        ST_LOW: begin
          if (rise) begin
            // Rise is checked before saturation so a period of exactly CNT_MAX still publishes.
            state_d      = ST_HIGH;
            per_cnt_d    = CNT_ONE;
            hi_cnt_d     = CNT_ONE;
            period_cnt_d = per_cnt_q;
            high_cnt_d   = hi_shadow_q;
            valid_d      = 1'b1;
            timeout_d    = 1'b0;
          end else if (per_sat) begin
            // Line stuck low: give up on this period and flag it.
            state_d   = ST_ARM;
            timeout_d = 1'b1;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
          end else begin
            per_cnt_d = per_inc;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
        end
      endcase
    end
  end

  // State and output registers; everything clears on reset.
  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      pwm_sync_q   <= '0;
      s_d_q        <= 1'b0;
      state_q      <= ST_IDLE;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      hi_shadow_q  <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      pwm_sync_q   <= pwm_sync_d;
      s_d_q        <= s_d_d;
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      hi_shadow_q  <= hi_shadow_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_high_cnt   = high_cnt_q;
  assign o_period_cnt = period_cnt_q;
  assign o_valid      = valid_q;
  assign o_timeout    = timeout_q;
  assign o_level      = pwm_sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 16-bit instance and a 4-bit instance share the stimulus.
// Each publish is logged at the falling edge and compared against hand-computed values.
// Stimulus changes 1 time unit after the rising edge.
module tb_pwm_capture;

  localparam int W  = 16;
  localparam int W4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          en;
  logic          pwm;
  logic [W-1:0]  hi, per;
  logic          vld, to, lvl;
  logic [W4-1:0] hi4, per4;
  logic          vld4, to4, lvl4;

  pwm_capture #(.CNT_W(W), .SYNC_STAGES(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pwm(pwm),
    .o_high_cnt(hi), .o_period_cnt(per), .o_valid(vld), .o_timeout(to), .o_level(lvl)
  );

  pwm_capture #(.CNT_W(W4), .SYNC_STAGES(2)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pwm(pwm),
    .o_high_cnt(hi4), .o_period_cnt(per4), .o_valid(vld4), .o_timeout(to4), .o_level(lvl4)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int q_hi[$], q_per[$], q_cyc[$];
  int q4_hi[$], q4_per[$];
  bit prev_vld  = 1'b0;
  bit b2b       = 1'b0;
  bit to4_seen  = 1'b0;

  always @(posedge clk) cyc++;

  // Publish logger, sampled away from the active edge.
  always @(negedge clk) begin
    if (vld === 1'b1) begin
      q_hi.push_back(int'(hi));
      q_per.push_back(int'(per));
      q_cyc.push_back(cyc);
    end
    if (vld === 1'b1 && prev_vld) b2b = 1'b1;
    prev_vld = (vld === 1'b1);
    if (vld4 === 1'b1) begin
      q4_hi.push_back(int'(hi4));
      q4_per.push_back(int'(per4));
    end
    if (to4 === 1'b1) to4_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_q();
    q_hi.delete(); q_per.delete(); q_cyc.delete();
    q4_hi.delete(); q4_per.delete();
    to4_seen = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; pwm = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    repeat (3) @(posedge clk);
    #1 clr_q();
  endtask

  // n periods of 'h' high cycles out of 'p', one level per clock.
  task automatic drive_pwm(input int h, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) begin
        @(posedge clk);
        #1 pwm = (c < h);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 pwm = 1'b0;
    end
  endtask

  // Check the logged 16-bit publishes against a constant high/period pair.
  task automatic chk_q(input string tag, input int n, input int eh, input int ep);
    chk({tag, "_n"}, q_hi.size(), n);
    for (int i = 0; i < q_hi.size() && i < n; i++) begin
      chk($sformatf("%s_hi%0d", tag, i), q_hi[i], eh);
      chk($sformatf("%s_per%0d", tag, i), q_per[i], ep);
    end
  endtask

  task automatic chk_q4(input string tag, input int n, input int eh, input int ep);
    chk({tag, "_n4"}, q4_hi.size(), n);
    for (int i = 0; i < q4_hi.size() && i < n; i++) begin
      chk($sformatf("%s_hi4_%0d", tag, i), q4_hi[i], eh);
      chk($sformatf("%s_per4_%0d", tag, i), q4_per[i], ep);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int sweep_h[9];
    int sweep_p[9];

    rst_n = 1'b0; en = 1'b0; pwm = 1'b0;
    #2;
    // Reset state.
    chk("rst_hi",   hi,   0);
    chk("rst_per",  per,  0);
    chk("rst_vld",  vld,  0);
    chk("rst_to",   to,   0);
    chk("rst_lvl",  lvl,  0);
    chk("rst_to4",  to4,  0);
    chk("rst_vld4", vld4, 0);

    // Test 1: steady 3/8, five publishes from six rises, 8 cycles apart.
    do_reset();
    drive_pwm(3, 8, 6);
    idle(12);
    chk_q("t1", 5, 3, 8);
    for (int i = 1; i < q_cyc.size(); i++)
      chk($sformatf("t1_gap%0d", i), q_cyc[i] - q_cyc[i-1], 8);

    // Test 2: duty sweep 1..7 of 8, then period 2 with high 1.
    do_reset();
    for (int h = 1; h <= 7; h++) drive_pwm(h, 8, 1);
    drive_pwm(1, 2, 3);
    idle(12);
    for (int i = 0; i < 7; i++) begin sweep_h[i] = i + 1; sweep_p[i] = 8; end
    sweep_h[7] = 1; sweep_p[7] = 2;
    sweep_h[8] = 1; sweep_p[8] = 2;
    chk("t2_n", q_hi.size(), 9);
    for (int i = 0; i < q_hi.size() && i < 9; i++) begin
      chk($sformatf("t2_hi%0d", i), q_hi[i], sweep_h[i]);
      chk($sformatf("t2_per%0d", i), q_per[i], sweep_p[i]);
    end
    if (q_cyc.size() == 9) chk("t2_gap_p2", q_cyc[8] - q_cyc[7], 2);

    // Test 3: 4-bit instance, line stuck high after a rise.
    do_reset();
    @(posedge clk);
    #1 pwm = 1'b1;
    repeat (17) @(posedge clk);
    @(negedge clk);
    chk("t3_to_early", to4, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t3_to_set", to4, 1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t3_to_sticky", to4, 1);
    chk("t3_lvl4", lvl4, 1);
    chk("t3_no_vld4", q4_hi.size(), 0);
    @(posedge clk);
    #1;
    drive_pwm(3, 8, 1);
    @(negedge clk);
    chk("t3_to_hold", to4, 1);
    @(posedge clk);
    #1;
    drive_pwm(3, 8, 3);
    @(negedge clk);
    chk_q4("t3", 2, 3, 8);
    chk("t3_to_clr", to4, 0);

    // Test 4: enable dropped for one cycle while the third period is high.
    do_reset();
    fork
      drive_pwm(3, 8, 6);
      begin
        repeat (20) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1 en = 1'b1;
        @(negedge clk);
        chk("t4_hold_hi", hi, 3);
        chk("t4_hold_per", per, 8);
      end
    join
    idle(4);
    chk_q("t4", 4, 3, 8);
    if (q_cyc.size() == 4) begin
      chk("t4_gap1", q_cyc[1] - q_cyc[0], 8);
      chk("t4_gap2", q_cyc[2] - q_cyc[1], 16);
      chk("t4_gap3", q_cyc[3] - q_cyc[2], 8);
    end

    // Test 5: reset asserted while the capture is in LOW.
    do_reset();
    fork
      drive_pwm(3, 8, 7);
      begin
        repeat (25) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_pre_n", q_hi.size(), 2);
        chk("t5_rst_hi", hi, 0);
        chk("t5_rst_per", per, 0);
        chk("t5_rst_vld", vld, 0);
        chk("t5_rst_to", to, 0);
        chk("t5_rst_lvl", lvl, 0);
        clr_q();
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    idle(4);
    chk_q("t5", 2, 3, 8);
    if (q_cyc.size() == 2) chk("t5_gap", q_cyc[1] - q_cyc[0], 8);

    // Test 6: period exactly 15 on the 4-bit instance; rise beats saturation.
    do_reset();
    drive_pwm(5, 15, 3);
    @(negedge clk);
    chk_q4("t6", 2, 5, 15);
    chk("t6_no_to", to4_seen, 0);
    chk_q("t6w", 2, 5, 15);

    // Period 16 saturates first on the 4-bit instance: timeout, no publish.
    do_reset();
    drive_pwm(5, 16, 3);
    @(negedge clk);
    chk("t6b_no_vld4", q4_hi.size(), 0);
    chk("t6b_to4", to4, 1);
    chk_q("t6bw", 2, 5, 16);

    chk("no_back2back", b2b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
